// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers and FSM state type for the LFSR-based timer family.
// lfsr_next is the single step function used by both lfsr and lfsr_timer;
// lfsr_advance walks a seed forward N steps to precompute terminal states.
package lfsr_pkg;

    // Timer FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_t;

    // Widest register the helpers handle; callers pass their real size
    localparam int unsigned LFSR_MAX_W = 64;

    // Bit mask covering the low 'size' stages
    function automatic logic [LFSR_MAX_W-1:0] lfsr_mask(input int unsigned size);
        logic [LFSR_MAX_W-1:0] m;
        if (size >= LFSR_MAX_W) begin
            m = '1;
        end else begin
            m = (64'd1 << size) - 64'd1;
        end
        return m;
    endfunction

    // Fibonacci step: shift left, feed back the parity of the tapped stages
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] poly,
        input int unsigned           size
    );
        logic [LFSR_MAX_W-1:0] m;
        logic                  fb;
        m  = lfsr_mask(size);
        fb = ^(s & poly & m);
        return ((s << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & m;
    endfunction

    // State reached from 'seed' after n steps; used to compute i_term
    function automatic logic [LFSR_MAX_W-1:0] lfsr_advance(
        input logic [LFSR_MAX_W-1:0] seed,
        input logic [LFSR_MAX_W-1:0] poly,
        input int unsigned           size,
        input int unsigned           n
    );
        logic [LFSR_MAX_W-1:0] s;
        s = seed & lfsr_mask(size);
        for (int unsigned i = 0; i < n; i++) begin
            s = lfsr_next(s, poly, size);
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_timer.sv
// LFSR countdown timer: steps an LFSR from SEED on each tick until it hits
// the terminal state captured at start. One-shot or periodic, with a done
// pulse, saturating expiry counter and sticky unreachable-terminal error.
module lfsr_timer
    import lfsr_pkg::*;
#(
    parameter logic [31:0]     POLY  = 32'b1101_0000_0000_1000,
    localparam int unsigned    SIZE  = $clog2(POLY),
    parameter logic [SIZE-1:0] SEED  = '1,
    parameter int unsigned     CNT_W = 8
) (
    input  logic             clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_tick,
    input  logic             i_periodic,
    input  logic [SIZE-1:0]  i_term,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_expiries,
    output logic [SIZE-1:0]  o_sreg
);

    // An all-zero seed locks the LFSR, so refuse it at elaboration
    if (SEED == '0) begin : g_seed_check
        $error("lfsr_timer: SEED must be non-zero");
    end

    lfsr_state_t      state;
    logic [SIZE-1:0]  sreg;
    logic [SIZE-1:0]  term_q;
    logic             per_q;
    logic             done_q;
    logic             error_q;
    logic [CNT_W-1:0] expiries_q;
    logic [SIZE-1:0]  nxt;

    // Next LFSR state from the shared package step function
    assign nxt = SIZE'(lfsr_next(64'(sreg), 64'(POLY), SIZE));

    // Control FSM, LFSR register and status outputs.
    // Priority: abort, then start, then a ticking RUN step where the
    // terminal match is tested before the full-period (SEED) check.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            sreg       <= SEED;
            term_q     <= '0;
            per_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            expiries_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (i_abort) begin
                state <= IDLE;
            end else if (i_start) begin
                state      <= RUN;
                sreg       <= SEED;
                term_q     <= i_term;
                per_q      <= i_periodic;
                error_q    <= 1'b0;
                expiries_q <= '0;
            end else if (state == RUN && i_tick) begin
                if (nxt == term_q) begin
                    done_q <= 1'b1;
                    if (expiries_q != '1) begin
                        expiries_q <= expiries_q + 1'b1;
                    end
                    if (per_q) begin
                        sreg <= SEED;
                    end else begin
                        sreg  <= nxt;
                        state <= IDLE;
                    end
                end else if (nxt == SEED) begin
                    error_q <= 1'b1;
                    state   <= IDLE;
                    sreg    <= nxt;
                end else begin
                    sreg <= nxt;
                end
            end
        end
    end

    // Outputs are direct register views
    always_comb begin
        o_busy     = (state == RUN);
        o_done     = done_q;
        o_error    = error_q;
        o_expiries = expiries_q;
        o_sreg     = sreg;
    end

endmodule
